assignment_update_controller: RTL and testbench
===============================================

ASSIGNMENT_UPDATE_CONTROLLER -- requirements
Module: assignment_update_controller

Interface
REQ-001 SHALL have parameter MAXIMUM_BIT_WIDTH_OF_INTEGER_VARIABLE_INDEX, default 2, log2 of the integer variable count (NI = 2**value).
REQ-002 SHALL have parameter MAXIMUM_BIT_WIDTH_OF_BOOLEAN_VARIABLE_INDEX, default 2, log2 of the boolean variable count (NB = 2**value).
REQ-003 SHALL have parameter MAXIMUM_BIT_WIDTH_OF_INTEGER_VARIABLE, default 4 (IW), signed integer value width.
REQ-004 SHALL have parameter MAXIMUM_BIT_WIDTH_OF_BOOLEAN_VARIABLE, default 2 (BW), boolean slot width.
REQ-005 SHALL have parameter COUNTER_WIDTH, default 16, width of the statistics counters.
REQ-006 Ports SHALL be as follows. Clock and reset: one clock; reset is synchronous and active-low.
- in_clk, input, 1: the single clock; all state updates on its rising edge.
- in_reset_n, input, 1: synchronous active-low reset.
- in_load, input, 1: load the initial assignment.
- in_init_integer_assignment, input, IW*NI: initial integer vector; variable j at bits [j*IW +: IW].
- in_init_boolean_assignment, input, BW*NB: initial boolean vector.
- in_move_valid, input, 1: move request.
- out_move_ready, output, 1: controller can accept a move.
- in_variable_index, input, log2 NI: index of the variable to move.
- in_new_assignment_for_variable, input, IW: proposed value.
- out_proposal_valid, output, 1: the proposed vector is stable and awaits a decision.
- out_proposed_integer_assignment, output, IW*NI: committed vector with one slot replaced.
- in_decision_valid, input, 1: decision strobe.
- in_decision_accept, input, 1: 1 = commit, 0 = reject.
- out_integer_assignment, output, IW*NI: committed integer vector.
- out_boolean_assignment, output, BW*NB: committed boolean vector.
- out_move_count, output, COUNTER_WIDTH: number of decided moves (statistics build only).
- out_accept_count, output, COUNTER_WIDTH: number of accepted moves (statistics build only).

Function
REQ-007 SHALL implement a two-state FSM with states IDLE and WAIT_DECISION.
REQ-008 out_move_ready SHALL equal (state==IDLE) && !in_load.
REQ-009 In IDLE with in_load=1, SHALL register both init vectors into the committed registers at the next edge; state stays IDLE.
REQ-010 In IDLE with in_move_valid && out_move_ready, SHALL capture index and value at that edge and enter WAIT_DECISION.
REQ-011 In WAIT_DECISION, out_proposal_valid SHALL be 1 (from the cycle after the handshake).
REQ-012 In WAIT_DECISION, out_proposed_integer_assignment SHALL equal the committed vector with slot [index] replaced by the captured value; all other slots SHALL be unchanged.
REQ-013 In all other cycles, out_proposed_integer_assignment SHALL equal out_integer_assignment.
REQ-014 In WAIT_DECISION with in_decision_valid=1 and accept=1, SHALL copy the proposed vector into the committed register at that edge and return to IDLE; with accept=0, SHALL return to IDLE with the committed register unchanged.
REQ-015 The earliest next handshake SHALL occur one cycle after the decision edge.
REQ-016 In WAIT_DECISION with in_load=1, load SHALL win: the proposal is discarded, init vectors are loaded, state becomes IDLE, and a simultaneous decision is ignored and not counted.
REQ-017 in_decision_valid in IDLE SHALL be ignored; in_move_valid in WAIT_DECISION SHALL be ignored (not captured).
REQ-018 The boolean vector SHALL change only on load.

Reset
REQ-019 When in_reset_n=0 at an edge, SHALL set state to IDLE, committed vectors to 0, captured index and value to 0, and counters to 0; after reset, out_proposal_valid=0 and out_move_ready=1.
REQ-020 Reset mid-WAIT_DECISION SHALL drop the proposal with no commit, and reset SHALL override load and decision inputs.

Configuration
REQ-021 With ASSIGNMENT_UPDATE_STATS_EN defined, each decided move SHALL increment out_move_count, and each accept SHALL also increment out_accept_count; both SHALL saturate at all-ones.
REQ-022 Without ASSIGNMENT_UPDATE_STATS_EN, both count outputs SHALL be tied to 0 and no counter flops SHALL exist.

Structure
REQ-023 The shared package SHALL hold the FSM state encoding (IDLE=0, WAIT_DECISION=1) and the default width constants.
REQ-024 Slot replacement SHALL be done by one instance of sub-module UpdateAssignment (index, value, committed vectors in, proposed vector out).

Verification (defaults)
REQ-025 Reset, then load int 0x4321 and bool 0xA5 -> next cycle out_integer_assignment=0x4321, out_boolean_assignment=0xA5, out_move_ready=1.
REQ-026 Move idx=2, val=0x7, then decision accept -> proposal 0x4721 while valid; committed 0x4721 after the decision edge; counts move=1, accept=1.
REQ-027 Move idx=0, val=0xF, then reject -> proposal 0x432F; committed stays 0x4321; counts move=1, accept=0.
REQ-028 In WAIT_DECISION, assert load 0x1111 together with decision accept -> committed=0x1111, state IDLE, counts unchanged.
REQ-029 in_move_valid held high across a decision -> second handshake exactly one cycle after the decision edge; a decision strobe in IDLE has no effect.
REQ-030 Stats build: preload the counter to all-ones via force, then accept -> the counter stays all-ones.

Source files
------------

// File: rtl/assignment_update_controller_pkg.sv
// Shared types and default widths for the assignment update controller.
package assignment_update_controller_pkg;

    typedef enum logic {
        IDLE          = 1'b0,
        WAIT_DECISION = 1'b1
    } auc_state_e;

    localparam int unsigned DEFAULT_INT_INDEX_WIDTH  = 2;
    localparam int unsigned DEFAULT_BOOL_INDEX_WIDTH = 2;
    localparam int unsigned DEFAULT_INT_WIDTH        = 4;
    localparam int unsigned DEFAULT_BOOL_WIDTH       = 2;
    localparam int unsigned DEFAULT_COUNTER_WIDTH    = 16;

endpackage

// File: rtl/assignment_update_controller_update_assignment.sv
// Combinational slot replacement: the committed vector with one integer slot overwritten.
module UpdateAssignment
    import assignment_update_controller_pkg::*;
#(
    parameter int unsigned INDEX_WIDTH = DEFAULT_INT_INDEX_WIDTH,
    parameter int unsigned INT_WIDTH   = DEFAULT_INT_WIDTH
) (
    input  logic [INDEX_WIDTH-1:0]                   in_variable_index,
    input  logic [INT_WIDTH-1:0]                     in_value,
    input  logic [INT_WIDTH*(2**INDEX_WIDTH)-1:0]    in_integer_assignment,
    output logic [INT_WIDTH*(2**INDEX_WIDTH)-1:0]    out_proposed_integer_assignment
);

    localparam int unsigned NI = 2**INDEX_WIDTH;

    always_comb begin
        out_proposed_integer_assignment = in_integer_assignment;
        for (int unsigned j = 0; j < NI; j++) begin
            if (INDEX_WIDTH'(j) == in_variable_index) begin
                out_proposed_integer_assignment[j*INT_WIDTH +: INT_WIDTH] = in_value;
            end
        end
    end

endmodule

// File: rtl/assignment_update_controller.sv
// Move/decide controller over a committed integer/boolean assignment.
// Optional statistics counters enabled by defining ASSIGNMENT_UPDATE_STATS_EN.
module assignment_update_controller
    import assignment_update_controller_pkg::*;
#(
    parameter int unsigned MAXIMUM_BIT_WIDTH_OF_INTEGER_VARIABLE_INDEX = DEFAULT_INT_INDEX_WIDTH,
    parameter int unsigned MAXIMUM_BIT_WIDTH_OF_BOOLEAN_VARIABLE_INDEX = DEFAULT_BOOL_INDEX_WIDTH,
    parameter int unsigned MAXIMUM_BIT_WIDTH_OF_INTEGER_VARIABLE       = DEFAULT_INT_WIDTH,
    parameter int unsigned MAXIMUM_BIT_WIDTH_OF_BOOLEAN_VARIABLE       = DEFAULT_BOOL_WIDTH,
    parameter int unsigned COUNTER_WIDTH                               = DEFAULT_COUNTER_WIDTH,
    localparam int unsigned IXW = MAXIMUM_BIT_WIDTH_OF_INTEGER_VARIABLE_INDEX,
    localparam int unsigned IW  = MAXIMUM_BIT_WIDTH_OF_INTEGER_VARIABLE,
    localparam int unsigned BW  = MAXIMUM_BIT_WIDTH_OF_BOOLEAN_VARIABLE,
    localparam int unsigned NI  = 2**MAXIMUM_BIT_WIDTH_OF_INTEGER_VARIABLE_INDEX,
    localparam int unsigned NB  = 2**MAXIMUM_BIT_WIDTH_OF_BOOLEAN_VARIABLE_INDEX
) (
    input  logic                     in_clk,
    input  logic                     in_reset_n,
    input  logic                     in_load,
    input  logic [IW*NI-1:0]         in_init_integer_assignment,
    input  logic [BW*NB-1:0]         in_init_boolean_assignment,
    input  logic                     in_move_valid,
    output logic                     out_move_ready,
    input  logic [IXW-1:0]           in_variable_index,
    input  logic [IW-1:0]            in_new_assignment_for_variable,
    output logic                     out_proposal_valid,
    output logic [IW*NI-1:0]         out_proposed_integer_assignment,
    input  logic                     in_decision_valid,
    input  logic                     in_decision_accept,
    output logic [IW*NI-1:0]         out_integer_assignment,
    output logic [BW*NB-1:0]         out_boolean_assignment,
    output logic [COUNTER_WIDTH-1:0] out_move_count,
    output logic [COUNTER_WIDTH-1:0] out_accept_count
);

    auc_state_e        state_q;
    logic [IW*NI-1:0]  int_q;
    logic [BW*NB-1:0]  bool_q;
    logic [IXW-1:0]    index_q;
    logic [IW-1:0]     value_q;
    logic [IW*NI-1:0]  replaced;
    logic              decide;

    UpdateAssignment #(
        .INDEX_WIDTH (IXW),
        .INT_WIDTH   (IW)
    ) u_update (
        .in_variable_index               (index_q),
        .in_value                        (value_q),
        .in_integer_assignment           (int_q),
        .out_proposed_integer_assignment (replaced)
    );

    assign out_move_ready                  = (state_q == IDLE) && !in_load;
    assign out_proposal_valid              = (state_q == WAIT_DECISION);
    assign out_proposed_integer_assignment = (state_q == WAIT_DECISION) ? replaced : int_q;
    assign out_integer_assignment          = int_q;
    assign out_boolean_assignment          = bool_q;
    // A decision only counts when load is not pre-empting it.
    assign decide = (state_q == WAIT_DECISION) && in_decision_valid && !in_load;

    always_ff @(posedge in_clk) begin
        if (!in_reset_n) begin
            state_q <= IDLE;
            int_q   <= '0;
            bool_q  <= '0;
            index_q <= '0;
            value_q <= '0;
        end else if (in_load) begin
            state_q <= IDLE;
            int_q   <= in_init_integer_assignment;
            bool_q  <= in_init_boolean_assignment;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_move_valid) begin
                        index_q <= in_variable_index;
                        value_q <= in_new_assignment_for_variable;
                        state_q <= WAIT_DECISION;
                    end
                end
                WAIT_DECISION: begin
                    if (in_decision_valid) begin
                        if (in_decision_accept) begin
                            int_q <= replaced;
                        end
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef ASSIGNMENT_UPDATE_STATS_EN
    logic [COUNTER_WIDTH-1:0] move_count_q;
    logic [COUNTER_WIDTH-1:0] accept_count_q;

    always_ff @(posedge in_clk) begin
        if (!in_reset_n) begin
            move_count_q   <= '0;
            accept_count_q <= '0;
        end else if (decide) begin
            if (move_count_q != '1) begin
                move_count_q <= move_count_q + 1'b1;
            end
            if (in_decision_accept && (accept_count_q != '1)) begin
                accept_count_q <= accept_count_q + 1'b1;
            end
        end
    end

    assign out_move_count   = move_count_q;
    assign out_accept_count = accept_count_q;
`else
    logic unused_decide;
    assign unused_decide    = decide;
    assign out_move_count   = '0;
    assign out_accept_count = '0;
`endif

endmodule

// File: tb/tb_assignment_update_controller.sv
// Self-checking bench: directed scenarios then random traffic against an array-based reference model.
module tb_assignment_update_controller;

    localparam int NI = 4;
    localparam int IW = 4;

    logic        in_clk = 1'b0;
    logic        in_reset_n, in_load, in_move_valid, in_decision_valid, in_decision_accept;
    logic [15:0] in_init_integer_assignment;
    logic [7:0]  in_init_boolean_assignment;
    logic [1:0]  in_variable_index;
    logic [3:0]  in_new_assignment_for_variable;
    logic        out_move_ready, out_proposal_valid;
    logic [15:0] out_proposed_integer_assignment, out_integer_assignment;
    logic [7:0]  out_boolean_assignment;
    logic [15:0] out_move_count, out_accept_count;

    int tests = 0;
    int fails = 0;

    // Reference model state
    int          m_int [NI];
    logic [7:0]  m_bool;
    bit          m_pending;
    int          m_idx, m_val;
    int          m_moves, m_accepts;

    always #5 in_clk = ~in_clk;

    assignment_update_controller dut (
        .in_clk                          (in_clk),
        .in_reset_n                      (in_reset_n),
        .in_load                         (in_load),
        .in_init_integer_assignment      (in_init_integer_assignment),
        .in_init_boolean_assignment      (in_init_boolean_assignment),
        .in_move_valid                   (in_move_valid),
        .out_move_ready                  (out_move_ready),
        .in_variable_index               (in_variable_index),
        .in_new_assignment_for_variable  (in_new_assignment_for_variable),
        .out_proposal_valid              (out_proposal_valid),
        .out_proposed_integer_assignment (out_proposed_integer_assignment),
        .in_decision_valid               (in_decision_valid),
        .in_decision_accept              (in_decision_accept),
        .out_integer_assignment          (out_integer_assignment),
        .out_boolean_assignment          (out_boolean_assignment),
        .out_move_count                  (out_move_count),
        .out_accept_count                (out_accept_count)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] pack_int(input bit with_proposal);
        logic [15:0] v;
        for (int j = 0; j < NI; j++) begin
            v[j*IW +: IW] = (with_proposal && j == m_idx) ? 4'(m_val) : 4'(m_int[j]);
        end
        return v;
    endfunction

    function automatic logic [15:0] exp_count(input int n);
`ifdef ASSIGNMENT_UPDATE_STATS_EN
        return 16'(n);
`else
        return (n > 0) ? 16'h0 : 16'h0;
`endif
    endfunction

    task automatic check_model(input string where);
        check({where, ".ready"},    32'(out_move_ready),     32'(!m_pending && !in_load));
        check({where, ".pvalid"},   32'(out_proposal_valid), 32'(m_pending));
        check({where, ".proposed"}, 32'(out_proposed_integer_assignment), 32'(pack_int(m_pending)));
        check({where, ".int"},      32'(out_integer_assignment), 32'(pack_int(1'b0)));
        check({where, ".bool"},     32'(out_boolean_assignment), 32'(m_bool));
        check({where, ".moves"},    32'(out_move_count),   32'(exp_count(m_moves)));
        check({where, ".accepts"},  32'(out_accept_count), 32'(exp_count(m_accepts)));
    endtask

    task automatic model_edge();
        if (!in_reset_n) begin
            foreach (m_int[j]) m_int[j] = 0;
            m_bool = '0; m_pending = 0; m_moves = 0; m_accepts = 0;
        end else if (in_load) begin
            for (int j = 0; j < NI; j++) m_int[j] = int'(in_init_integer_assignment[j*IW +: IW]);
            m_bool = in_init_boolean_assignment;
            m_pending = 0;
        end else if (m_pending) begin
            if (in_decision_valid) begin
                if (m_moves < 65535) m_moves++;
                if (in_decision_accept) begin
                    m_int[m_idx] = m_val;
                    if (m_accepts < 65535) m_accepts++;
                end
                m_pending = 0;
            end
        end else if (in_move_valid) begin
            m_idx = int'(in_variable_index);
            m_val = int'(in_new_assignment_for_variable);
            m_pending = 1;
        end
    endtask

    task automatic cyc(input string where, input logic rst_n, input logic ld, input logic mv,
                       input logic dv, input logic acc, input logic [1:0] idx, input logic [3:0] val,
                       input logic [15:0] ii, input logic [7:0] ib);
        in_reset_n = rst_n; in_load = ld; in_move_valid = mv; in_decision_valid = dv;
        in_decision_accept = acc; in_variable_index = idx; in_new_assignment_for_variable = val;
        in_init_integer_assignment = ii; in_init_boolean_assignment = ib;
        #1;
        check_model(where);
        @(posedge in_clk);
        model_edge();
        #1;
    endtask

    task automatic quiet();
        in_reset_n = 1'b1; in_load = 1'b0; in_move_valid = 1'b0; in_decision_valid = 1'b0;
        in_decision_accept = 1'b0;
        #1;
    endtask

    initial begin
        foreach (m_int[j]) m_int[j] = 0;
        m_bool = '0; m_pending = 0; m_idx = 0; m_val = 0; m_moves = 0; m_accepts = 0;
        in_reset_n = 1'b0; in_load = 1'b0; in_move_valid = 1'b0; in_decision_valid = 1'b0;
        in_decision_accept = 1'b0; in_variable_index = '0; in_new_assignment_for_variable = '0;
        in_init_integer_assignment = '0; in_init_boolean_assignment = '0;
        @(posedge in_clk); #1;
        @(posedge in_clk); model_edge(); #1;

        // Reset state
        quiet();
        check("rst.ready",  32'(out_move_ready), 32'd1);
        check("rst.pvalid", 32'(out_proposal_valid), 32'd0);
        check("rst.int",    32'(out_integer_assignment), 32'h0);

        // Load
        cyc("load", 1, 1, 0, 0, 0, 2'd0, 4'h0, 16'h4321, 8'hA5);
        quiet();
        check("load.int",   32'(out_integer_assignment), 32'h4321);
        check("load.bool",  32'(out_boolean_assignment), 32'hA5);
        check("load.ready", 32'(out_move_ready), 32'd1);

        // Move idx2=7, accept
        cyc("mv1", 1, 0, 1, 0, 0, 2'd2, 4'h7, 16'h0, 8'h0);
        quiet();
        check("mv1.proposed", 32'(out_proposed_integer_assignment), 32'h4721);
        check("mv1.pvalid",   32'(out_proposal_valid), 32'd1);
        cyc("acc1", 1, 0, 0, 1, 1, 2'd0, 4'h0, 16'h0, 8'h0);
        quiet();
        check("acc1.int", 32'(out_integer_assignment), 32'h4721);
        check("acc1.moves",   32'(out_move_count),   32'(exp_count(1)));
        check("acc1.accepts", 32'(out_accept_count), 32'(exp_count(1)));

        // Reset, reload, move idx0=F, reject
        cyc("rst2", 0, 0, 0, 0, 0, 2'd0, 4'h0, 16'h0, 8'h0);
        cyc("load2", 1, 1, 0, 0, 0, 2'd0, 4'h0, 16'h4321, 8'hA5);
        cyc("mv2", 1, 0, 1, 0, 0, 2'd0, 4'hF, 16'h0, 8'h0);
        quiet();
        check("mv2.proposed", 32'(out_proposed_integer_assignment), 32'h432F);
        cyc("rej2", 1, 0, 0, 1, 0, 2'd0, 4'h0, 16'h0, 8'h0);
        quiet();
        check("rej2.int",     32'(out_integer_assignment), 32'h4321);
        check("rej2.moves",   32'(out_move_count),   32'(exp_count(1)));
        check("rej2.accepts", 32'(out_accept_count), 32'(exp_count(0)));

        // Load beats a simultaneous accept
        cyc("mv3", 1, 0, 1, 0, 0, 2'd1, 4'h9, 16'h0, 8'h0);
        cyc("ldacc", 1, 1, 0, 1, 1, 2'd0, 4'h0, 16'h1111, 8'h3C);
        quiet();
        check("ldacc.int",    32'(out_integer_assignment), 32'h1111);
        check("ldacc.pvalid", 32'(out_proposal_valid), 32'd0);
        check("ldacc.moves",  32'(out_move_count), 32'(exp_count(1)));

        // move_valid held through a decision; re-handshake on the following cycle
        cyc("hold1", 1, 0, 1, 0, 0, 2'd3, 4'h5, 16'h0, 8'h0);
        cyc("hold2", 1, 0, 1, 0, 0, 2'd0, 4'h6, 16'h0, 8'h0);
        cyc("hold3", 1, 0, 1, 1, 1, 2'd1, 4'h8, 16'h0, 8'h0);
        cyc("hold4", 1, 0, 1, 0, 0, 2'd2, 4'hA, 16'h0, 8'h0);
        quiet();
        check("hold.pvalid",   32'(out_proposal_valid), 32'd1);
        check("hold.proposed", 32'(out_proposed_integer_assignment), 32'h5A11);
        cyc("hold5", 1, 0, 0, 1, 0, 2'd0, 4'h0, 16'h0, 8'h0);
        // Decision strobe while idle is ignored
        cyc("idle_dec", 1, 0, 0, 1, 1, 2'd0, 4'h0, 16'h0, 8'h0);
        quiet();
        check("idle_dec.int", 32'(out_integer_assignment), 32'h5111);

        // Reset mid-proposal drops it, overriding load and decision
        cyc("mv4", 1, 0, 1, 0, 0, 2'd0, 4'h2, 16'h0, 8'h0);
        cyc("rst4", 0, 1, 0, 1, 1, 2'd0, 4'h0, 16'hFFFF, 8'hFF);
        quiet();
        check("rst4.int",    32'(out_integer_assignment), 32'h0);
        check("rst4.pvalid", 32'(out_proposal_valid), 32'd0);

`ifdef ASSIGNMENT_UPDATE_STATS_EN
        // Saturation
        cyc("sat_mv", 1, 0, 1, 0, 0, 2'd1, 4'h3, 16'h0, 8'h0);
        force dut.move_count_q = 16'hFFFF;
        force dut.accept_count_q = 16'hFFFF;
        #1;
        release dut.move_count_q;
        release dut.accept_count_q;
        m_moves = 65535; m_accepts = 65535;
        cyc("sat_acc", 1, 0, 0, 1, 1, 2'd0, 4'h0, 16'h0, 8'h0);
        quiet();
        check("sat.moves",   32'(out_move_count),   32'hFFFF);
        check("sat.accepts", 32'(out_accept_count), 32'hFFFF);
`endif

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            logic rn, ld, mv, dv, ac;
            rn = ($urandom_range(0, 63) != 0);
            ld = ($urandom_range(0, 15) == 0);
            mv = 1'($urandom);
            dv = 1'($urandom);
            ac = 1'($urandom);
            cyc("rand", rn, ld, mv, dv, ac, 2'($urandom), 4'($urandom), 16'($urandom), 8'($urandom));
        end
        quiet();
        check_model("final");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
